// File: rtl/run_gen_pkg.sv
// Shared definitions for the run_gen block.
//   rg_state_t : FSM state encoding (IDLE / FILL / SHIFT)
//   RG_W       : default output word width
package run_gen_pkg;

    typedef enum logic [1:0] {
        RG_IDLE  = 2'd0,
        RG_FILL  = 2'd1,
        RG_SHIFT = 2'd2
    } rg_state_t;

    localparam int RG_W = 32;

endpackage

// File: rtl/rg_downcnt.sv
// Loadable down-counter used for the run-length and position counts.
// Ports:
//   clk_i      : clock, state updates on the falling edge
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; a count of zero stays at zero
//   q_o        : current count
//   is_one_o   : count equals one (last step of the owning state)
module rg_downcnt #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         dec_i,
    output logic [N-1:0] q_o,
    output logic         is_one_o
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            // Guarded so the count can never wrap below zero.
            cnt_d = cnt_q - N'(1);
        end
    end

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o      = cnt_q;
    assign is_one_o = (cnt_q == N'(1));

endmodule

// File: rtl/run_gen.sv
// Serial run generator: builds a W-bit word holding a single run of
// min(len, W) ones whose LSB sits at bit pos, one shift per clock.
// Ones pushed past bit W-1 are dropped, so the visible run is
// min(len, W-pos) bits long.
// Handshake: start_i is a request sampled on every falling edge and always
// wins (it restarts generation from any state); rdy_o is high exactly
// while idle, and y_o is the finished word whenever rdy_o is high.
// Ports:
//   clk_i   : clock, all state changes on the falling edge
//   rst_i   : synchronous active-high reset, priority over start_i
//   start_i : capture len_i/pos_i and begin generation
//   len_i   : run length, values above W saturate to W
//   pos_i   : bit index of the run LSB
//   rdy_o   : idle / result valid
//   y_o     : generated word (registered, held while idle)
//   state_o : current FSM state, for debug
module run_gen
    import run_gen_pkg::*;
#(
    parameter int W  = RG_W,
    parameter int LW = $clog2(W) + 1,
    parameter int PW = $clog2(W)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic [PW-1:0] pos_i,
    output logic          rdy_o,
    output logic [W-1:0]  y_o,
    output rg_state_t     state_o
);

    rg_state_t     state_q, state_d;
    logic [W-1:0]  y_q, y_d;
    logic [LW-1:0] len_sat;
    logic [LW-1:0] lcnt_q;
    logic [PW-1:0] pcnt_q;
    logic          lcnt_one, pcnt_one;
    logic          l_dec, p_dec;

    assign len_sat = (len_i > LW'(W)) ? LW'(W) : len_i;

    rg_downcnt #(.N(LW)) u_lcnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (start_i),
        .load_val_i (len_sat),
        .dec_i      (l_dec),
        .q_o        (lcnt_q),
        .is_one_o   (lcnt_one)
    );

    rg_downcnt #(.N(PW)) u_pcnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (start_i),
        .load_val_i (pos_i),
        .dec_i      (p_dec),
        .q_o        (pcnt_q),
        .is_one_o   (pcnt_one)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        l_dec   = 1'b0;
        p_dec   = 1'b0;
        if (start_i) begin
            y_d     = '0;
            // A zero-length request never leaves IDLE.
            state_d = (len_sat != '0) ? RG_FILL : RG_IDLE;
        end else begin
            case (state_q)
                RG_FILL: begin
                    y_d   = {y_q[W-2:0], 1'b1};
                    l_dec = 1'b1;
                    if (lcnt_one) begin
                        state_d = (pcnt_q != '0) ? RG_SHIFT : RG_IDLE;
                    end
                end
                RG_SHIFT: begin
                    y_d   = {y_q[W-2:0], 1'b0};
                    p_dec = 1'b1;
                    if (pcnt_one) begin
                        state_d = RG_IDLE;
                    end
                end
                default: begin
                    state_d = RG_IDLE;
                end
            endcase
        end
    end

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            state_q <= RG_IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign rdy_o   = (state_q == RG_IDLE);
    assign y_o     = y_q;
    assign state_o = state_q;

    // lcnt_q is only consumed through is_one; keep it visibly used.
    logic unused_lcnt;
    assign unused_lcnt = ^lcnt_q;

endmodule

// File: tb/tb_run_gen.sv
module tb_run_gen;
    import run_gen_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [5:0]   len;
    logic [4:0]   pos;
    logic         rdy;
    logic [W-1:0] y;
    rg_state_t    state;

    int tests_run = 0;
    int fails     = 0;

    run_gen dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .len_i   (len),
        .pos_i   (pos),
        .rdy_o   (rdy),
        .y_o     (y),
        .state_o (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Word after k generation steps of a request with run length l and offset p.
    function automatic logic [W-1:0] model_y(input int l, input int k);
        logic [63:0] t;
        if (k <= l) t = (64'd1 << k) - 64'd1;
        else        t = ((64'd1 << l) - 64'd1) << (k - l);
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] final_word(input int l, input int p);
        logic [63:0] t;
        t = ((64'd1 << l) - 64'd1) << p;
        return t[W-1:0];
    endfunction

    logic [W-1:0] exp_q[$];
    bit           m_valid = 0;
    bit           m_busy  = 0;
    bit           m_done  = 0;
    logic [W-1:0] m_y     = '0;
    int           m_l, m_p, m_k;

    always @(negedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_busy  = 0;
            m_done  = 0;
            m_y     = '0;
            exp_q.delete();
        end else if (m_valid) begin
            if (start) begin
                m_l    = (int'(len) > W) ? W : int'(len);
                m_p    = int'(pos);
                m_k    = 0;
                m_y    = '0;
                m_busy = (m_l != 0);
                m_done = 0;
                exp_q.delete();
                if (m_busy) exp_q.push_back(final_word(m_l, m_p));
            end else if (m_busy) begin
                m_k++;
                m_y = model_y(m_l, m_k);
                if (m_k == m_l + m_p) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        if (m_valid) begin
            check("rdy_cycle", {31'd0, rdy}, {31'd0, !m_busy});
            check("y_cycle", y, m_y);
            if (m_done) begin
                m_done = 0;
                if (exp_q.size() == 0) begin
                    check("final_queue_empty", 32'd1, 32'd0);
                end else begin
                    check("final_word", y, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [5:0] l, input logic [4:0] p);
        @(posedge clk);
        start = 1'b1;
        len   = l;
        pos   = p;
        @(posedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges after the start edge until rdy is seen high.
    task automatic wait_rdy(input int max_edges, output int edges);
        edges = 0;
        for (int n = 1; n <= max_edges; n++) begin
            @(posedge clk);
            if (rdy) begin
                edges = n;
                return;
            end
        end
        check("wait_rdy_timeout", 32'd0, 32'd1);
        edges = -1;
    endtask

    task automatic run_case(input string name, input logic [5:0] l, input logic [4:0] p,
                            input int exp_edges, input logic [W-1:0] exp_y);
        int e;
        do_start(l, p);
        wait_rdy(100, e);
        check({name, "_edges"}, e, exp_edges);
        check({name, "_y"}, y, exp_y);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int e;
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        pos   = '0;

        // 1. reset for two edges, then idle
        repeat (2) @(posedge clk);
        rst = 1'b0;
        check("reset_y", y, 32'h0);
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        repeat (3) @(posedge clk);
        check("idle_y", y, 32'h0);
        check("idle_rdy", {31'd0, rdy}, 32'd1);

        // 2-5. main cases
        run_case("len3_pos0", 6'd3, 5'd0, 3, 32'h0000_0007);
        run_case("len4_pos8", 6'd4, 5'd8, 12, 32'h0000_0F00);
        run_case("len40_sat", 6'd40, 5'd0, 32, 32'hFFFF_FFFF);
        run_case("len5_pos30", 6'd5, 5'd30, 35, 32'hC000_0000);
        check("len5_pos30_ones", $countones(y), 32'd2);
        run_case("len32_pos0", 6'd32, 5'd0, 32, 32'hFFFF_FFFF);
        run_case("len1_pos31", 6'd1, 5'd31, 32, 32'h8000_0000);
        run_case("len63_pos4", 6'd63, 5'd4, 36, 32'hFFFF_FFF0);

        // 6. zero length: rdy never drops, then restart
        do_start(6'd0, 5'd5);
        check("len0_rdy_a", {31'd0, rdy}, 32'd1);
        check("len0_y_a", y, 32'h0);
        @(posedge clk);
        check("len0_rdy_b", {31'd0, rdy}, 32'd1);
        check("len0_y_b", y, 32'h0);
        run_case("len2_pos1", 6'd2, 5'd1, 3, 32'h0000_0006);

        // reset mid-FILL
        do_start(6'd10, 5'd0);
        repeat (3) @(posedge clk);
        check("midfill_busy", {31'd0, rdy}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        check("midrst_y", y, 32'h0);
        check("midrst_rdy", {31'd0, rdy}, 32'd1);

        // start held high keeps reloading
        @(posedge clk);
        start = 1'b1;
        len   = 6'd2;
        pos   = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            check("held_rdy", {31'd0, rdy}, 32'd0);
            check("held_y", y, 32'h0);
        end
        start = 1'b0;
        wait_rdy(100, e);
        check("held_edges", e, 32'd2);
        check("held_final", y, 32'h0000_0003);

        // inputs changed while busy are ignored
        do_start(6'd3, 5'd2);
        len = 6'd20;
        pos = 5'd9;
        wait_rdy(100, e);
        check("ignore_edges", e, 32'd5);
        check("ignore_y", y, 32'h0000_001C);

        // restart while busy abandons the first operation
        do_start(6'd8, 5'd8);
        repeat (2) @(posedge clk);
        run_case("restart", 6'd1, 5'd1, 2, 32'h0000_0002);

        repeat (3) @(posedge clk);
        check("end_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
